// File: rtl/ps2_key_events_pkg.sv
// Shared PS/2 decoder definitions: FSM states, protocol byte constants and
// the layout of a key event.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Keyboard status/ack bytes that carry no key information.
  localparam int NUM_DISCARD = 6;
  localparam logic [NUM_DISCARD*8-1:0] DISCARD_CODES =
    {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  localparam int EV_W   = 10;
  localparam int EV_BRK = 9;
  localparam int EV_EXT = 8;

  function automatic logic is_discard(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_DISCARD; i++) begin
      if (b == DISCARD_CODES[8*i +: 8]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through FIFO; the head entry is visible on pop_data while
// not empty, and a pop plus push on a full FIFO both succeed.
module key_event_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Masked so the head reads zero when nothing is queued.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ps2_key_events.sv
// PS/2 scancode decoder: assembles make/break/extended byte sequences into
// 10-bit events, buffers them and tracks held state for mapped keys.
//   state      | meaning
//   ST_IDLE    | no prefix seen
//   ST_EXT     | 0xE0 seen
//   ST_BRK     | 0xF0 seen
//   ST_EXT_BRK | 0xE0 0xF0 seen
module ps2_key_events
  import ps2_pkg::*;
#(
  parameter int                    FIFO_DEPTH  = 8,
  parameter int                    NUM_KEYS    = 4,
  parameter logic [NUM_KEYS*9-1:0] KEY_MAP     = {9'h0_23, 9'h0_1B, 9'h0_1C, 9'h0_1D},
  parameter int                    TIMEOUT_CYC = 50_000_000
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [7:0]                    received_data,
  input  logic                          received_data_en,
  input  logic                          rd_en,
  output logic [EV_W-1:0]               rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  input  logic                          clr_overflow,
  output logic [NUM_KEYS-1:0]           key_down
);

  // Down-counter loaded on every byte; expiring at zero puts the FSM back in
  // IDLE exactly TIMEOUT_CYC cycles after that byte.
  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 2);

  ps2_state_e       state;
  ps2_state_e       state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nxt;
  logic             emit;
  logic [EV_W-1:0]  ev;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    emit      = 1'b0;
    ev        = '0;
    if (received_data_en) begin
      tmr_nxt = TMR_LOAD;
      unique case (state)
        ST_IDLE: begin
          if (received_data == PS2_EXT)       state_nxt = ST_EXT;
          else if (received_data == PS2_BRK)  state_nxt = ST_BRK;
          else if (!is_discard(received_data)) begin
            emit = 1'b1;
            ev   = {1'b0, 1'b0, received_data};
          end
        end
        ST_EXT: begin
          if (received_data == PS2_BRK)       state_nxt = ST_EXT_BRK;
          else if (received_data != PS2_EXT) begin
            state_nxt = ST_IDLE;
            emit      = 1'b1;
            ev        = {1'b0, 1'b1, received_data};
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          state_nxt = ST_IDLE;
          if (received_data != PS2_EXT && received_data != PS2_BRK) begin
            emit = 1'b1;
            ev   = {1'b1, (state == ST_EXT_BRK), received_data};
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (state != ST_IDLE) begin
      if (tmr == '0) state_nxt = ST_IDLE;
      else           tmr_nxt   = tmr - 1'b1;
    end
    if (state_nxt == ST_IDLE) tmr_nxt = '0;
  end

  key_event_fifo #(
    .W     (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (RST),
    .push      (emit),
    .push_data (ev),
    .pop       (rd_en),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign rd_valid = !fifo_empty;
  assign drop     = emit && fifo_full && !rd_en;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Held-key state follows every decoded event, even one the FIFO dropped.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      key_down <= '0;
    end else if (emit) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (KEY_MAP[9*i +: 9] == ev[EV_EXT:0]) key_down[i] <= !ev[EV_BRK];
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_events.sv
// Bench for ps2_key_events: directed scenarios plus random byte streams,
// checked against a queue-based model of prefixes, FIFO and held keys.
module tb_ps2_key_events;

  localparam int DEPTH = 8;
  localparam int NK    = 4;
  localparam int TO    = 20;
  localparam logic [NK*9-1:0] MAP = {9'h0_23, 9'h0_1B, 9'h0_1C, 9'h0_1D};

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] received_data = '0;
  logic       received_data_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_overflow = 1'b0;
  logic [9:0] rd_data;
  logic       rd_valid;
  logic [3:0] count;
  logic       overflow;
  logic [3:0] key_down;

  always #5 CLK = ~CLK;

  ps2_key_events #(
    .FIFO_DEPTH  (DEPTH),
    .NUM_KEYS    (NK),
    .KEY_MAP     (MAP),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .rd_en            (rd_en),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .count            (count),
    .overflow         (overflow),
    .clr_overflow     (clr_overflow),
    .key_down         (key_down)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [9:0]     q[$];
  bit             m_pend, m_ext, m_brk;
  int             m_since;
  bit             m_ovf;
  logic [NK-1:0]  m_kd;
  logic [NK*9-1:0] map_v;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit is_junk(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
  endfunction

  // Model of one clock edge given the inputs that were presented to it.
  task automatic model_step(input bit en, input logic [7:0] b, input bit rd, input bit clr);
    bit         have;
    bit         set;
    logic [9:0] ev;
    have = 0; set = 0; ev = '0;
    if (en) begin
      if (!m_pend) begin
        if (b == 8'hE0)      begin m_pend = 1; m_ext = 1; m_brk = 0; end
        else if (b == 8'hF0) begin m_pend = 1; m_ext = 0; m_brk = 1; end
        else if (!is_junk(b)) begin have = 1; ev = {2'b00, b}; end
      end else if (m_ext && !m_brk) begin
        if (b == 8'hF0)      m_brk = 1;
        else if (b != 8'hE0) begin have = 1; ev = {2'b01, b}; m_pend = 0; end
      end else begin
        m_pend = 0;
        if (b != 8'hE0 && b != 8'hF0) begin have = 1; ev = {m_brk, m_ext, b}; end
      end
      m_since = 0;
    end else if (m_pend) begin
      m_since++;
      if (m_since >= TO - 1) m_pend = 0;
    end
    if (rd && q.size() > 0) void'(q.pop_front());
    if (have) begin
      for (int i = 0; i < NK; i++)
        if (map_v[9*i +: 9] == ev[8:0]) m_kd[i] = !ev[9];
      if (q.size() == DEPTH) set = 1;
      else q.push_back(ev);
    end
    if (set) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".rd_valid"}, rd_valid, q.size() > 0);
    check_eq({tag, ".count"},    count,    q.size());
    check_eq({tag, ".rd_data"},  rd_data,  (q.size() > 0) ? q[0] : 10'h000);
    check_eq({tag, ".overflow"}, overflow, m_ovf);
    check_eq({tag, ".key_down"}, key_down, m_kd);
  endtask

  task automatic step(input bit en, input logic [7:0] b, input bit rd, input bit clr);
    received_data_en = en;
    received_data    = b;
    rd_en            = rd;
    clr_overflow     = clr;
    @(posedge CLK);
    #1;
    model_step(en, b, rd, clr);
    received_data_en = 0;
    rd_en            = 0;
    clr_overflow     = 0;
    compare_all("step");
  endtask

  task automatic do_reset(input string tag);
    received_data_en = 0;
    rd_en            = 0;
    clr_overflow     = 0;
    received_data    = '0;
    RST = 0;
    #2;
    q.delete();
    m_pend = 0; m_ext = 0; m_brk = 0; m_since = 0; m_ovf = 0; m_kd = '0;
    compare_all(tag);
    @(posedge CLK);
    #1;
    RST = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0] pool [12];

  initial begin
    map_v = MAP;
    pool = '{8'hE0, 8'hF0, 8'h1C, 8'h1D, 8'h1B, 8'h23, 8'h75, 8'hAA,
             8'hFA, 8'h00, 8'h14, 8'hE0};
    do_reset("reset");

    // plain make then break
    step(1, 8'h1C, 0, 0);
    check_eq("plain.kd_make", key_down[1], 1'b1);
    step(1, 8'hF0, 0, 0);
    step(1, 8'h1C, 0, 0);
    check_eq("plain.kd_break", key_down[1], 1'b0);
    check_eq("plain.count", count, 4'd2);
    check_eq("plain.head0", rd_data, 10'h01C);
    step(0, 8'h00, 1, 0);
    check_eq("plain.head1", rd_data, 10'h21C);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);

    // extended break, then status bytes
    step(1, 8'hE0, 0, 0);
    step(1, 8'hF0, 0, 0);
    step(1, 8'h75, 0, 0);
    check_eq("extbrk.head", rd_data, 10'h375);
    check_eq("extbrk.kd", key_down, 4'h0);
    step(1, 8'hAA, 0, 0);
    step(1, 8'hFA, 0, 0);
    check_eq("extbrk.count", count, 4'd1);
    step(0, 8'h00, 1, 0);

    // overflow and the full-with-pop case
    repeat (9) step(1, 8'h1D, 0, 0);
    check_eq("ovf.count", count, 4'd8);
    check_eq("ovf.flag", overflow, 1'b1);
    check_eq("ovf.kd0", key_down[0], 1'b1);
    step(0, 8'h00, 0, 1);
    check_eq("ovf.clr", overflow, 1'b0);
    step(1, 8'h1D, 1, 0);
    check_eq("ovf.full_pop_count", count, 4'd8);
    check_eq("ovf.full_pop_flag", overflow, 1'b0);
    repeat (8) step(0, 8'h00, 1, 0);
    check_eq("ovf.drained", count, 4'd0);

    // timeout boundary: one cycle early keeps the break prefix
    step(1, 8'hF0, 0, 0);
    repeat (TO - 2) step(0, 8'h00, 0, 0);
    step(1, 8'h1B, 0, 0);
    check_eq("tmo.early_head", rd_data, 10'h21B);
    step(0, 8'h00, 1, 0);
    step(1, 8'hF0, 0, 0);
    repeat (TO - 1) step(0, 8'h00, 0, 0);
    step(1, 8'h1B, 0, 0);
    check_eq("tmo.head", rd_data, 10'h01B);
    check_eq("tmo.kd2", key_down[2], 1'b1);
    step(0, 8'h00, 1, 0);

    // reset mid-sequence drops the extended prefix
    step(1, 8'hE0, 0, 0);
    do_reset("mid_reset");
    step(1, 8'h1D, 0, 0);
    check_eq("rst.head", rd_data, 10'h01D);
    step(0, 8'h00, 1, 0);

    // FWFT ordering with back-to-back pops
    step(1, 8'h1C, 0, 0);
    step(1, 8'h1B, 0, 0);
    step(1, 8'h23, 0, 0);
    check_eq("fwft.head0", rd_data, 10'h01C);
    step(0, 8'h00, 1, 0);
    check_eq("fwft.head1", rd_data, 10'h01B);
    step(0, 8'h00, 1, 0);
    check_eq("fwft.head2", rd_data, 10'h023);
    step(0, 8'h00, 1, 0);
    check_eq("fwft.valid", rd_valid, 1'b0);
    step(0, 8'h00, 1, 0);
    check_eq("fwft.empty_pop", count, 4'd0);

    // random traffic with occasional long gaps
    for (int k = 0; k < 3000; k++) begin
      logic [7:0] b;
      bit en, rd, clr;
      if ($urandom_range(0, 9) == 0) b = 8'($urandom_range(0, 255));
      else b = pool[$urandom_range(0, 11)];
      en  = ($urandom_range(0, 99) < 55);
      rd  = ($urandom_range(0, 99) < 30);
      clr = ($urandom_range(0, 99) < 5);
      step(en, b, rd, clr);
      if ($urandom_range(0, 49) == 0) begin
        int gap;
        gap = $urandom_range(TO - 3, TO + 1);
        for (int g = 0; g < gap; g++) step(0, 8'h00, $urandom_range(0, 3) == 0, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
